parking_slot_allocator: RTL and testbench

Sequential, parametrised slot manager for the parking controller. It tracks the occupancy of `N_SLOTS` parking bays and grants a free bay to each entering car through a request/acknowledge handshake. It releases bays on exit, rejecting invalid exits, and maintains the occupancy count and full/empty flags. It sits between the gate sensor logic and the display/capacity outputs. It replaces the earlier combinational capacity-update logic.

---
 rtl/parking_slot_allocator_if.sv | 28 ++
 rtl/parking_slot_allocator.sv | 131 +++++++++++++
 tb/tb_parking_slot_allocator.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_slot_allocator_if.sv
// Gate-side handshake and status bundle for the parking slot allocator.
// master = gate sensor logic, slave = allocator.
interface parking_slot_allocator_if #(
  parameter int N_SLOTS = 8,
  parameter int ID_W    = $clog2(N_SLOTS),
  parameter int CNT_W   = $clog2(N_SLOTS+1)
);
  logic               enter_req;
  logic               enter_ack;
  logic [ID_W-1:0]    enter_slot;
  logic               exit_req;
  logic [ID_W-1:0]    exit_slot;
  logic               exit_ack;
  logic               exit_err;
  logic [N_SLOTS-1:0] slot_map;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
  logic               empty;

  modport master (
    output enter_req, exit_req, exit_slot,
    input  enter_ack, enter_slot, exit_ack, exit_err, slot_map, occupancy, full, empty
  );
  modport slave (
    input  enter_req, exit_req, exit_slot,
    output enter_ack, enter_slot, exit_ack, exit_err, slot_map, occupancy, full, empty
  );
endinterface

// File: rtl/parking_slot_allocator.sv
// Parking bay allocator: entry/exit handshake FSMs, occupancy map and count.
// Define PARK_ROUND_ROBIN_EN to rotate the bay search start after each grant.
module parking_slot_allocator #(
  parameter int N_SLOTS = 8,
  parameter int ID_W    = $clog2(N_SLOTS),
  parameter int CNT_W   = $clog2(N_SLOTS+1)
) (
  input  logic clk,
  input  logic rst_n,
  parking_slot_allocator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESP, DROP} ch_state_t;

  localparam logic [ID_W:0]    N_ID  = (ID_W+1)'(N_SLOTS);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SLOTS);

  ch_state_t          en_st, en_nx, ex_st, ex_nx;
  logic               en_go, ex_go, ex_hit, found;
  logic [N_SLOTS-1:0] slot_map, free_rot, set_mask, clr_mask;
  logic [ID_W-1:0]    off, pick, e_slot;
  logic [CNT_W-1:0]   occ, occ_nx;
  logic               full_q, empty_q, e_ack, x_ack, x_err;

`ifdef PARK_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W:0]   pick_sum;

  // Search the free map rotated so that bit 0 is the pointer position.
  always_comb begin
    free_rot = N_SLOTS'({~slot_map, ~slot_map} >> rr_ptr);
    pick_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (pick_sum >= N_ID) pick_sum = pick_sum - N_ID;
    pick = pick_sum[ID_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rr_ptr <= '0;
    else if (en_go) rr_ptr <= (pick == ID_W'(N_SLOTS-1)) ? '0 : pick + ID_W'(1);
`else
  always_comb begin
    free_rot = ~slot_map;
    pick     = off;
  end
`endif

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (!found && free_rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
  end

  // Out-of-range indices never match a bit, so they fall through to err.
  always_comb begin
    ex_hit = 1'b0;
    for (int i = 0; i < N_SLOTS; i++)
      if (bus.exit_slot == ID_W'(i) && slot_map[i]) ex_hit = 1'b1;
  end

  always_comb begin
    en_nx = en_st;
    ex_nx = ex_st;
    en_go = 1'b0;
    ex_go = 1'b0;
    case (en_st)
      IDLE:    if (bus.enter_req && !full_q && found) begin en_go = 1'b1; en_nx = RESP; end
      RESP:    en_nx = DROP;
      DROP:    if (!bus.enter_req) en_nx = IDLE;
      default: en_nx = IDLE;
    endcase
    case (ex_st)
      IDLE:    if (bus.exit_req) begin ex_go = 1'b1; ex_nx = RESP; end
      RESP:    ex_nx = DROP;
      DROP:    if (!bus.exit_req) ex_nx = IDLE;
      default: ex_nx = IDLE;
    endcase
  end

  // The granted bay was free before the edge, so it never collides with a release.
  always_comb begin
    set_mask = en_go ? (N_SLOTS'(1) << pick) : '0;
    clr_mask = (ex_go && ex_hit) ? (N_SLOTS'(1) << bus.exit_slot) : '0;
    case ({en_go, ex_go && ex_hit})
      2'b10:   occ_nx = occ + CNT_W'(1);
      2'b01:   occ_nx = occ - CNT_W'(1);
      default: occ_nx = occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en_st <= IDLE;
      ex_st <= IDLE;
    end else begin
      en_st <= en_nx;
      ex_st <= ex_nx;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_map <= '0;
      occ      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      e_ack    <= 1'b0;
      x_ack    <= 1'b0;
      x_err    <= 1'b0;
      e_slot   <= '0;
    end else begin
      slot_map <= (slot_map & ~clr_mask) | set_mask;
      occ      <= occ_nx;
      full_q   <= (occ_nx == N_CNT);
      empty_q  <= (occ_nx == '0);
      e_ack    <= en_go;
      x_ack    <= ex_go && ex_hit;
      x_err    <= ex_go && !ex_hit;
      if (en_go) e_slot <= pick;
    end

  assign bus.enter_ack  = e_ack;
  assign bus.enter_slot = e_slot;
  assign bus.exit_ack   = x_ack;
  assign bus.exit_err   = x_err;
  assign bus.slot_map   = slot_map;
  assign bus.occupancy  = occ;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
endmodule

// File: tb/tb_parking_slot_allocator.sv
// Self-checking bench for parking_slot_allocator against a bay-array reference model.
module tb_parking_slot_allocator;
  localparam int N  = 8;
  localparam int IW = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miss = 0;

  bit m_map[N];
  int m_ptr = 0;

  parking_slot_allocator_if #(.N_SLOTS(N), .ID_W(IW), .CNT_W(CW)) bus ();
  parking_slot_allocator #(.N_SLOTS(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_map[i]);
    return c;
  endfunction

  function automatic logic [N+CW+1:0] m_status();
    logic [N-1:0] mp;
    int c;
    for (int i = 0; i < N; i++) mp[i] = m_map[i];
    c = m_count();
    return {mp, CW'(c), c == N, c == 0};
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < N; k++)
      if (!m_map[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void m_grant(int idx);
    m_map[idx] = 1'b1;
`ifdef PARK_ROUND_ROBIN_EN
    m_ptr = (idx + 1) % N;
`endif
  endfunction

  function automatic bit m_release(int s);
    if (s < N && m_map[s]) begin
      m_map[s] = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) m_map[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic logic [N+CW+1:0] obs();
    return {bus.slot_map, bus.occupancy, bus.full, bus.empty};
  endfunction

  // ---------------- drivers (all start and end just after a negedge) ----------------
  task automatic drive_enter(output bit ok, output int lat, output logic [IW-1:0] slot, output bit stuck);
    ok = 1'b0; lat = 0; slot = '0; stuck = 1'b0;
    bus.enter_req = 1'b1;
    while (!ok && lat < 30) begin
      @(negedge clk); lat++;
      if (bus.enter_ack === 1'b1) begin ok = 1'b1; slot = bus.enter_slot; end
    end
    bus.enter_req = 1'b0;
    @(negedge clk); stuck = (bus.enter_ack !== 1'b0);
    @(negedge clk);
  endtask

  task automatic drive_exit(input int s, output bit ack, output bit err, output int lat);
    ack = 1'b0; err = 1'b0; lat = 0;
    bus.exit_slot = IW'(s);
    bus.exit_req  = 1'b1;
    while (!(ack || err) && lat < 30) begin
      @(negedge clk); lat++;
      ack = bus.exit_ack; err = bus.exit_err;
    end
    bus.exit_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enter_req = 1'b0; bus.exit_req = 1'b0; bus.exit_slot = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.enter_req = 1'b0; bus.exit_req = 1'b0; bus.exit_slot = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs() !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
      miss++; $display("FAIL reset_status: got %h want %h", obs(), {8'h00, 4'h0, 1'b0, 1'b1});
    end
    vectors++;
    if ({bus.enter_ack, bus.exit_ack, bus.exit_err} !== 3'b000 || bus.enter_slot !== 4'h0) begin
      miss++; $display("FAIL reset_pulses: got ack/ack/err %b slot %0d want 000 slot 0",
                       {bus.enter_ack, bus.exit_ack, bus.exit_err}, bus.enter_slot);
    end
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
  endtask

  task automatic test_fill();
    bit ok, stuck;
    int lat, acks, exp;
    logic [IW-1:0] slot;
    for (int i = 0; i < N; i++) begin
      exp = m_pick();
      drive_enter(ok, lat, slot, stuck);
      vectors++;
      if (!ok || lat != 1 || stuck || slot !== IW'(exp)) begin
        miss++; $display("FAIL fill_grant[%0d]: ok=%0d lat=%0d stuck=%0d slot=%0d want slot %0d lat 1",
                         i, ok, lat, stuck, slot, exp);
      end
      m_grant(exp);
      vectors++;
      if (obs() !== m_status()) begin
        miss++; $display("FAIL fill_status[%0d]: got %h want %h", i, obs(), m_status());
      end
    end
    bus.enter_req = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.enter_ack !== 1'b0) acks++;
    end
    vectors++;
    if (acks != 0) begin
      miss++; $display("FAIL full_blocks_entry: got %0d acks want 0", acks);
    end
  endtask

  // Entry request from test_fill is still pending while the exit releases bay 3.
  task automatic test_full_exit();
    int exp;
    bus.exit_slot = 4'd3;
    bus.exit_req  = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.exit_ack, bus.exit_err, bus.enter_ack} !== 3'b100) begin
      miss++; $display("FAIL full_exit_ack: got ack/err/eack %b want 100",
                       {bus.exit_ack, bus.exit_err, bus.enter_ack});
    end
    void'(m_release(3));
    bus.exit_req = 1'b0;
    exp = m_pick();
    @(negedge clk);
    vectors++;
    if (bus.enter_ack !== 1'b1 || bus.enter_slot !== IW'(exp)) begin
      miss++; $display("FAIL full_exit_regrant: got ack %b slot %0d want ack 1 slot %0d",
                       bus.enter_ack, bus.enter_slot, exp);
    end
    m_grant(exp);
    bus.enter_req = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs() !== m_status()) begin
      miss++; $display("FAIL full_exit_status: got %h want %h", obs(), m_status());
    end
  endtask

  task automatic test_invalid_exit();
    bit ok, stuck, ack, err;
    int lat;
    logic [IW-1:0] slot;
    int bad[2] = '{5, 9};
    do_reset();
    repeat (2) begin
      m_grant(m_pick());
      drive_enter(ok, lat, slot, stuck);
    end
    foreach (bad[j]) begin
      drive_exit(bad[j], ack, err, lat);
      vectors++;
      if (ack !== m_release(bad[j]) || err === ack || lat != 1) begin
        miss++; $display("FAIL invalid_exit[%0d]: got ack %b err %b lat %0d want err only lat 1",
                         bad[j], ack, err, lat);
      end
      vectors++;
      if (obs() !== m_status()) begin
        miss++; $display("FAIL invalid_exit_map[%0d]: got %h want %h", bad[j], obs(), m_status());
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok, stuck;
    int lat, exp;
    logic [IW-1:0] slot;
    do_reset();
    repeat (4) begin
      m_grant(m_pick());
      drive_enter(ok, lat, slot, stuck);
    end
    exp = m_pick();
    bus.enter_req = 1'b1;
    bus.exit_slot = 4'd1;
    bus.exit_req  = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.enter_ack, bus.exit_ack, bus.exit_err} !== 3'b110 || bus.enter_slot !== IW'(exp) || exp != 4) begin
      miss++; $display("FAIL simul_ack: got eack/xack/xerr %b slot %0d want 110 slot 4",
                       {bus.enter_ack, bus.exit_ack, bus.exit_err}, bus.enter_slot);
    end
    m_grant(exp);
    void'(m_release(1));
    vectors++;
    if (obs() !== m_status()) begin
      miss++; $display("FAIL simul_status: got %h want %h", obs(), m_status());
    end
    bus.enter_req = 1'b0;
    bus.exit_req  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ok, stuck, ack, err;
    int lat, exp, want_const;
    logic [IW-1:0] slot;
    do_reset();
    m_grant(m_pick());
    drive_enter(ok, lat, slot, stuck);
    drive_exit(0, ack, err, lat);
    void'(m_release(0));
    exp = m_pick();
    drive_enter(ok, lat, slot, stuck);
    m_grant(exp);
`ifdef PARK_ROUND_ROBIN_EN
    want_const = 1;
`else
    want_const = 0;
`endif
    vectors++;
    if (!ok || slot !== IW'(exp) || slot !== IW'(want_const)) begin
      miss++; $display("FAIL rr_second_grant: got ok %0d slot %0d want slot %0d", ok, slot, want_const);
    end
  endtask

  task automatic test_random();
    bit ok, stuck, ack, err, want;
    int lat, exp, s;
    logic [IW-1:0] slot;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0 && m_count() < N) begin
        exp = m_pick();
        drive_enter(ok, lat, slot, stuck);
        vectors++;
        if (!ok || lat != 1 || stuck || slot !== IW'(exp)) begin
          miss++; $display("FAIL rand_enter[%0d]: ok=%0d lat=%0d slot=%0d want slot %0d", n, ok, lat, slot, exp);
        end
        m_grant(exp);
      end else begin
        s = int'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1 && m_count() > 0)
          do s = int'($urandom_range(0, N-1)); while (!m_map[s]);
        drive_exit(s, ack, err, lat);
        want = m_release(s);
        vectors++;
        if (ack !== want || err !== !want || lat != 1) begin
          miss++; $display("FAIL rand_exit[%0d]: slot %0d got ack %b err %b lat %0d want ack %b",
                           n, s, ack, err, lat, want);
        end
      end
      vectors++;
      if (obs() !== m_status()) begin
        miss++; $display("FAIL rand_status[%0d]: got %h want %h", n, obs(), m_status());
      end
    end
  endtask

  // Reset landing in the cycle an ack is high must clear it without waiting for a clock.
  task automatic test_reset_midflight();
    do_reset();
    bus.enter_req = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.enter_ack !== 1'b1) begin
      miss++; $display("FAIL midflight_pre: got ack %b want 1", bus.enter_ack);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.enter_ack !== 1'b0 || bus.slot_map !== 8'h00 || bus.empty !== 1'b1) begin
      miss++; $display("FAIL midflight_abort: got ack %b map %h empty %b want 0 00 1",
                       bus.enter_ack, bus.slot_map, bus.empty);
    end
    @(negedge clk);
    bus.enter_req = 1'b0;
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
  endtask

  initial begin
    bus.enter_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.exit_slot = '0;
    test_reset();
    test_fill();
    test_full_exit();
    test_invalid_exit();
    test_simultaneous();
    test_round_robin();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
